// File: rtl/cla_sub_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cla_sub_pipe_pkg
// Shared definitions for the pipelined carry-lookahead subtractor:
//   CSP_SLICE / CSP_WIDTH : default slice and operand widths
//   CSP_STAGES            : derived pipeline depth (one slice per stage)
//   stage_t               : per-stage record at default widths
//   sub_ovf()             : two's-complement overflow rule for a - b
// ---------------------------------------------------------------------------
package cla_sub_pipe_pkg;

    localparam int unsigned CSP_SLICE  = 4;
    localparam int unsigned CSP_WIDTH  = 16;
    localparam int unsigned CSP_STAGES = CSP_WIDTH / CSP_SLICE;

    typedef struct packed {
        logic                 valid;
        logic [CSP_WIDTH-1:0] a;
        logic [CSP_WIDTH-1:0] b;
        logic [CSP_WIDTH-1:0] diff;
        logic                 carry;
    } stage_t;

    // Subtraction overflows when the operands differ in sign and the
    // result sign differs from the minuend sign.
    function automatic logic sub_ovf(input logic a_msb,
                                     input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_sub_pipe_slice.sv
// ---------------------------------------------------------------------------
// cla_slice
// Combinational W-bit carry-lookahead adder slice.
//   i_a, i_b : addends (the caller inverts the subtrahend)
//   i_cin    : carry in
//   o_sum    : i_a + i_b + i_cin, low W bits
//   o_cout   : carry out of the slice
// ---------------------------------------------------------------------------
module cla_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;
    logic         w_prod;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is a flat sum of products:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    // w_prod accumulates the propagate chain walking down from bit i.
    always_comb begin
        w_c    = '0;
        w_prod = 1'b0;
        w_c[0] = i_cin;
        for (int unsigned i = 0; i < W; i++) begin
            w_c[i+1] = w_g[i];
            w_prod   = w_p[i];
            for (int unsigned j = 0; j < i; j++) begin
                w_c[i+1] = w_c[i+1] | (w_prod & w_g[i-1-j]);
                w_prod   = w_prod & w_p[i-1-j];
            end
            w_c[i+1] = w_c[i+1] | (w_prod & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[W-1:0];
    assign o_cout = w_c[W];

endmodule

// File: rtl/cla_sub_pipe.sv
// ---------------------------------------------------------------------------
// cla_sub_pipe
// Elastic pipelined subtractor, diff = a - b - bin, one CLA slice per stage.
// The carry of each slice is registered and consumed by the next stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, bout, ovf)
//   bout                : unsigned borrow (a < b + bin)
//   ovf                 : signed overflow
// ---------------------------------------------------------------------------
module cla_sub_pipe
    import cla_sub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = CSP_WIDTH,
    parameter int unsigned SLICE = CSP_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / SLICE;

    // Same layout as stage_t, sized by this instance's parameters.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             carry;
    } stg_t;

    stg_t             r_stg [STAGES];
    logic             r_bout;
    logic             r_ovf;

    stg_t             w_src [STAGES];
    stg_t             w_nxt [STAGES];
    logic [SLICE-1:0] w_sum [STAGES];
    logic             w_cout[STAGES];
    logic [STAGES:0]  w_rdy;

    // Stage k works on what stage k-1 holds; stage 0 works on the input beat.
    // Carry-in of slice 0 is ~bin since a - b - bin = a + ~b + ~bin.
    always_comb begin
        w_src[0].valid = in_valid;
        w_src[0].a     = a;
        w_src[0].b     = b;
        w_src[0].diff  = '0;
        w_src[0].carry = ~bin;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_src[k] = r_stg[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_slice #(.W(SLICE)) u_slice (
            .i_a   (w_src[k].a[k*SLICE +: SLICE]),
            .i_b   (~w_src[k].b[k*SLICE +: SLICE]),
            .i_cin (w_src[k].carry),
            .o_sum (w_sum[k]),
            .o_cout(w_cout[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_nxt[k]                          = w_src[k];
            w_nxt[k].diff[k*SLICE +: SLICE] = w_sum[k];
            w_nxt[k].carry                    = w_cout[k];
        end
    end

    // Ready propagates backwards from the consumer: a stage can take a new
    // beat if it is empty or its downstream neighbour is taking its beat.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_rdy[STAGES-1-i] = !r_stg[STAGES-1-i].valid || w_rdy[STAGES-i];
        end
    end

    // The last stage doubles as the output register; its diff and the flag
    // registers are reset so the outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_stg[k].valid <= 1'b0;
            end
            r_stg[STAGES-1].diff <= '0;
            r_bout               <= 1'b0;
            r_ovf                <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_stg[k] <= w_nxt[k];
                end
            end
            if (w_rdy[STAGES-1]) begin
                r_bout <= ~w_nxt[STAGES-1].carry;
                r_ovf  <= sub_ovf(w_nxt[STAGES-1].a[WIDTH-1],
                                  w_nxt[STAGES-1].b[WIDTH-1],
                                  w_nxt[STAGES-1].diff[WIDTH-1]);
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_stg[STAGES-1].valid;
    assign diff      = r_stg[STAGES-1].diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_sub_pipe
// Directed self-checking bench for cla_sub_pipe (WIDTH=16, SLICE=4).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cla_sub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    cla_sub_pipe #(
        .WIDTH(16),
        .SLICE(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference subtraction in plain 17-bit arithmetic: {ovf, bout, diff}.
    function automatic logic [17:0] sub_ref(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic        c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} - {1'b0, y} - {16'h0, c};
        v = (x[15] != y[15]) && (t[15] != x[15]);
        return {v, t[16], t[15:0]};
    endfunction

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vbin;
        logic [15:0] vd;
        logic        vbo;
        logic        vov;
    } vec_t;

    vec_t vecs[7];

    logic [15:0] bp_a  [8];
    logic [15:0] bp_b  [8];
    logic        bp_bin[8];
    logic [17:0] bp_exp[8];

    task automatic run_single(input int idx);
        int lat;
        @(negedge clk);
        a        = vecs[idx].va;
        b        = vecs[idx].vb;
        bin      = vecs[idx].vbin;
        in_valid = 1'b1;
        #1;
        check_eq($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("v%0d_latency", idx), 32'(lat), 32'd4);
        check_eq($sformatf("v%0d_diff", idx), 32'(diff), 32'(vecs[idx].vd));
        check_eq($sformatf("v%0d_bout", idx), 32'(bout), 32'(vecs[idx].vbo));
        check_eq($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(vecs[idx].vov));
    endtask

    initial begin
        int rx;
        int sent;
        int extra;
        int cyc;

        // a, b, bin, diff, bout, ovf -- worked out by hand
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        for (int i = 0; i < 8; i++) begin
            bp_a[i]   = 16'(32'h2000 + i * 32'h0101);
            bp_b[i]   = 16'(32'h0100 + i * 32'h1000);
            bp_bin[i] = i[0];
            bp_exp[i] = sub_ref(bp_a[i], bp_b[i], bp_bin[i]);
        end

        // ---------------- reset ----------------
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_bout", 32'(bout), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid_after", 32'(out_valid), 32'd0);

        // ---------------- directed single beats ----------------
        for (int i = 0; i < 7; i++) begin
            run_single(i);
        end

        // ---------------- back-to-back streaming ----------------
        out_ready = 1'b1;
        rx = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check_eq($sformatf("strm%0d_cycle", rx), 32'(c), 32'(4 + rx));
                check_eq($sformatf("strm%0d_diff", rx), 32'(diff),
                         32'(16'(rx * 32'h1110)));
                check_eq($sformatf("strm%0d_flags", rx), 32'({bout, ovf}), 32'd0);
                rx++;
            end
            if (c < 8) begin
                a        = 16'(c * 32'h1111);
                b        = 16'(c);
                bin      = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check_eq("strm_count", 32'(rx), 32'd8);

        // ---------------- back-pressure ----------------
        sent = 0;
        rx   = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                check_eq($sformatf("bp_hold%0d_diff", c), 32'(diff),
                         32'(bp_exp[0][15:0]));
            end
            if (sent < 8) begin
                a        = bp_a[sent];
                b        = bp_b[sent];
                bin      = bp_bin[sent];
                in_valid = 1'b1;
            end
            #1;
            if (in_valid && in_ready) sent++;
        end
        check_eq("bp_accepts", 32'(sent), 32'd4);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);

        cyc = 0;
        while (rx < 8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (out_valid) begin
                check_eq($sformatf("bp%0d_diff", rx), 32'(diff), 32'(bp_exp[rx][15:0]));
                check_eq($sformatf("bp%0d_bout", rx), 32'(bout), 32'(bp_exp[rx][16]));
                check_eq($sformatf("bp%0d_ovf", rx), 32'(ovf), 32'(bp_exp[rx][17]));
                rx++;
            end
            if (sent < 8) begin
                a        = bp_a[sent];
                b        = bp_b[sent];
                bin      = bp_bin[sent];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) sent++;
        end
        check_eq("bp_drained", 32'(rx), 32'd8);
        in_valid = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check_eq("bp_no_dup", 32'(extra), 32'd0);

        // ---------------- reset mid-flight ----------------
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a        = (c == 1) ? 16'h0000 : 16'h8000;
            b        = 16'h0001;
            bin      = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_diff", 32'(diff), 32'd0);
        check_eq("midrst_flags", 32'({bout, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check_eq("midrst_no_stale", 32'(extra), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
